// File: rtl/salsa_core_param.sv
// Parametrised Salsa20 core: DOUBLE_ROUNDS double-rounds, DR_PER_CYCLE per clock,
// optional pre-XOR of a second operand and optional feed-forward, valid/ready on both sides.

module salsa_qr (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [31:0] c,
  input  logic [31:0] d,
  output logic [31:0] na,
  output logic [31:0] nb,
  output logic [31:0] nc,
  output logic [31:0] nd
);
  function automatic logic [31:0] rotl(input logic [31:0] v, input int s);
    return (v << s) | (v >> (32 - s));
  endfunction

  assign nb = b  ^ rotl(a  + d,  7);
  assign nc = c  ^ rotl(nb + a,  9);
  assign nd = d  ^ rotl(nc + nb, 13);
  assign na = a  ^ rotl(nd + nc, 18);
endmodule

module salsa_dround (
  input  logic [15:0][31:0] din,
  output logic [15:0][31:0] dout
);
  logic [15:0][31:0] col;

  // Column lane k works on (5k, 4(k+1)+k, 4(k+2)+k, 4(k+3)+k) mod 16; the row round is its transpose.
  for (genvar k = 0; k < 4; k++) begin : g_lane
    localparam int CA = 5 * k;
    localparam int CB = 4 * ((k + 1) % 4) + k;
    localparam int CC = 4 * ((k + 2) % 4) + k;
    localparam int CD = 4 * ((k + 3) % 4) + k;
    localparam int RA = 5 * k;
    localparam int RB = 4 * k + (k + 1) % 4;
    localparam int RC = 4 * k + (k + 2) % 4;
    localparam int RD = 4 * k + (k + 3) % 4;

    salsa_qr u_col (
      .a(din[CA]), .b(din[CB]), .c(din[CC]), .d(din[CD]),
      .na(col[CA]), .nb(col[CB]), .nc(col[CC]), .nd(col[CD])
    );
    salsa_qr u_row (
      .a(col[RA]), .b(col[RB]), .c(col[RC]), .d(col[RD]),
      .na(dout[RA]), .nb(dout[RB]), .nc(dout[RC]), .nd(dout[RD])
    );
  end
endmodule

module salsa_core_param #(
  parameter int DOUBLE_ROUNDS = 4,
  parameter int DR_PER_CYCLE  = 1,
  parameter int FEEDFORWARD   = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         xor_en,
  input  logic [511:0] x_in,
  input  logic [511:0] y_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [511:0] out_data,
  output logic         busy
);
  localparam int N  = DOUBLE_ROUNDS / DR_PER_CYCLE;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  if (DOUBLE_ROUNDS < 1 || DR_PER_CYCLE < 1 || (DOUBLE_ROUNDS % DR_PER_CYCLE) != 0) begin : g_bad_cfg
    $error("salsa_core_param: DR_PER_CYCLE must evenly divide DOUBLE_ROUNDS (>=1)");
  end

  typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_t;

  fsm_t              fsm;
  logic [CW-1:0]     cnt;
  logic [15:0][31:0] st, orig, st_next, res;
  logic              accept;

  for (genvar j = 0; j < DR_PER_CYCLE; j++) begin : g_dr
    logic [15:0][31:0] din, dout;
    if (j == 0) begin : g_first
      assign din = st;
    end else begin : g_next
      assign din = g_dr[j-1].dout;
    end
    salsa_dround u_dr (.din(din), .dout(dout));
  end
  assign st_next = g_dr[DR_PER_CYCLE-1].dout;

  for (genvar i = 0; i < 16; i++) begin : g_ff
    assign res[i] = (FEEDFORWARD != 0) ? st_next[i] + orig[i] : st_next[i];
  end

  assign in_ready  = (fsm == IDLE) || (fsm == DONE && out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = (fsm == DONE);
  assign busy      = (fsm == RUN);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fsm      <= IDLE;
      cnt      <= '0;
      st       <= '0;
      orig     <= '0;
      out_data <= '0;
    end else begin
      case (fsm)
        IDLE, DONE: begin
          // Accept in DONE doubles as the output handshake (back-to-back).
          if (accept) begin
            st   <= x_in ^ (xor_en ? y_in : 512'd0);
            orig <= x_in ^ (xor_en ? y_in : 512'd0);
            cnt  <= '0;
            fsm  <= RUN;
          end else if (fsm == DONE && out_ready) begin
            fsm <= IDLE;
          end
        end
        RUN: begin
          st <= st_next;
          if (cnt == CW'(N - 1)) begin
            out_data <= res;
            fsm      <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: fsm <= IDLE;
      endcase
    end
  end
endmodule
